// File: rtl/uart_autobaud.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_autobaud
//
// Auto-baud controller for the UART oversampling clock generator. When armed
// with i_start it waits for the RX line to sit idle, then times a 0x55 sync
// character. It derives the divider that gives 16 oversample ticks per bit
// and drives it onto o_div.
//
// The clock generator produces one tick every (div+1) clocks, so one bit lasts
// 16*(div+1) clocks. The span from the start-bit falling edge to the bit7
// falling edge is 8 bit times, or 128*(div+1) clocks. The divider is therefore
// round(N/128) - 1.
//
// Ports:
//   i_clk     clock
//   i_rst     asynchronous, active-high reset
//   i_rx      raw asynchronous RX line (synchronized internally)
//   i_start   one-cycle pulse that arms a measurement (ignored while busy)
//   o_div     divider for the clock generator (DEFAULT_DIV after reset)
//   o_busy    high while armed or measuring
//   o_locked  high after a successful measurement
//   o_done    one-cycle pulse when a measurement succeeds
//   o_err     one-cycle pulse when a measurement fails
//
// Optional build macro:
//   AUTOBAUD_CHECK_EN  when defined, each two-bit interval between falling
//                      edges must lie within T0/8 of the first interval.
//                      Otherwise the measurement is rejected.
// ---------------------------------------------------------------------------
module uart_autobaud #(
   parameter int                  DIV_BITS    = 10,
   parameter logic [DIV_BITS-1:0] DEFAULT_DIV = DIV_BITS'(26),
   parameter int                  IDLE_CYC    = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_rx,
   input  logic                i_start,
   output logic [DIV_BITS-1:0] o_div,
   output logic                o_busy,
   output logic                o_locked,
   output logic                o_done,
   output logic                o_err
);

   localparam int CNT_W  = DIV_BITS + 7;
   localparam int CALC_W = DIV_BITS + 8;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] IDLE_TARGET = CNT_W'(IDLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_WAIT_START,
      S_MEASURE,
      S_CALC
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
   logic [1:0]        edges, edges_nxt;
   logic [DIV_BITS-1:0] div_nxt;
   logic              locked_nxt, done_nxt, err_nxt;

   logic              rx_meta, rx_sync, rx_prev;
   logic              fall;

   logic [CALC_W-1:0] sum_w, r_w, div_full;
   logic              r_too_small;
   logic              calc_unused;
   logic              interval_bad;

`ifdef AUTOBAUD_CHECK_EN
   logic [CNT_W-1:0]  ivl, ivl_nxt, ivl_inc;
   logic [CNT_W-1:0]  t0, t0_nxt;
   logic [CNT_W-1:0]  ivl_diff;
`endif

   // Two-flop synchronizer followed by a registered copy used for edge
   // detection. Everything resets high so reset does not look like a start
   // edge. The synchronizer delay is the same for every edge, so it cancels
   // out of the edge-to-edge timing.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   // Saturating increment. In MEASURE, saturation means the character never
   // arrived.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // The divider is round(N/128) - 1. Adding 64 before the shift rounds to
   // nearest. The arithmetic is one bit wider than the counter so the sum
   // cannot overflow.
   assign sum_w       = CALC_W'(cnt) + CALC_W'(64);
   assign r_w         = sum_w >> 7;
   assign r_too_small = (r_w < CALC_W'(2));
   assign div_full    = r_w - CALC_W'(1);
   assign calc_unused = ^div_full[CALC_W-1:DIV_BITS];

`ifdef AUTOBAUD_CHECK_EN
   // Interval check: each two-bit interval after the first must be within
   // T0/8 of T0. The first edge (edges == 0) only records T0.
   assign ivl_inc      = (ivl == CNT_MAX) ? ivl : ivl + CNT_W'(1);
   assign ivl_diff     = (ivl >= t0) ? (ivl - t0) : (t0 - ivl);
   assign interval_bad = (edges != 2'd0) && (ivl_diff > (t0 >> 3));
`else
   assign interval_bad = 1'b0;
`endif

   // State and datapath register. o_div, o_locked, o_done and o_err are
   // registered, so o_div and o_done change together one clock after CALC.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         edges    <= 2'd0;
         o_div    <= DEFAULT_DIV;
         o_locked <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;
`ifdef AUTOBAUD_CHECK_EN
         ivl      <= '0;
         t0       <= '0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         edges    <= edges_nxt;
         o_div    <= div_nxt;
         o_locked <= locked_nxt;
         o_done   <= done_nxt;
         o_err    <= err_nxt;
`ifdef AUTOBAUD_CHECK_EN
         ivl      <= ivl_nxt;
         t0       <= t0_nxt;
`endif
      end
   end

   // Next-state logic. The single counter does two jobs: it counts idle
   // cycles in WAIT_IDLE and the span since the start edge in MEASURE. On
   // the final edge the counter holds its value, so CALC sees N directly.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      edges_nxt  = edges;
      div_nxt    = o_div;
      locked_nxt = o_locked;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
`ifdef AUTOBAUD_CHECK_EN
      ivl_nxt    = ivl;
      t0_nxt     = t0;
`endif

      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nxt  = S_WAIT_IDLE;
               cnt_nxt    = '0;
               locked_nxt = 1'b0;
            end
         end

         S_WAIT_IDLE: begin
            if (!rx_sync) begin
               cnt_nxt = '0;
            end else if (cnt == IDLE_TARGET) begin
               state_nxt = S_WAIT_START;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end

         S_WAIT_START: begin
            if (fall) begin
               state_nxt = S_MEASURE;
               cnt_nxt   = CNT_W'(1);
               edges_nxt = 2'd0;
`ifdef AUTOBAUD_CHECK_EN
               ivl_nxt   = CNT_W'(1);
`endif
            end
         end

         S_MEASURE: begin
            if (fall) begin
`ifdef AUTOBAUD_CHECK_EN
               if (edges == 2'd0) begin
                  t0_nxt = ivl;
               end
               ivl_nxt = CNT_W'(1);
`endif
               if (interval_bad) begin
                  state_nxt = S_IDLE;
                  err_nxt   = 1'b1;
               end else if (edges == 2'd3) begin
                  state_nxt = S_CALC;
               end else begin
                  edges_nxt = edges + 2'd1;
                  cnt_nxt   = cnt_inc;
               end
            end else if (cnt == CNT_MAX) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
`ifdef AUTOBAUD_CHECK_EN
               ivl_nxt = ivl_inc;
`endif
            end
         end

         S_CALC: begin
            state_nxt = S_IDLE;
            if (r_too_small) begin
               err_nxt = 1'b1;
            end else begin
               div_nxt    = div_full[DIV_BITS-1:0];
               locked_nxt = 1'b1;
               done_nxt   = 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_autobaud
//
// Scoreboard bench for uart_autobaud. Stimulus tasks push the expected
// done/err event onto a queue before sending a sync character. A monitor
// pops the queue whenever o_done or o_err pulses and compares the event kind,
// o_div and o_locked. A narrower divider keeps the saturation span short.
// ---------------------------------------------------------------------------
module tb_uart_autobaud;

   localparam int                  DIV_BITS    = 6;
   localparam logic [DIV_BITS-1:0] DEFAULT_DIV = 6'd26;
   localparam int                  IDLE_CYC    = 64;

   typedef struct packed {
      logic                is_err;
      logic [DIV_BITS-1:0] div;
      logic                locked;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                rx;
   logic                start;
   logic [DIV_BITS-1:0] o_div;
   logic                o_busy;
   logic                o_locked;
   logic                o_done;
   logic                o_err;

   exp_t  exp_q[$];
   exp_t  mon_e;
   int    nCompared   = 0;
   int    nMismatched = 0;
   string curTest     = "reset";

   uart_autobaud #(
      .DIV_BITS    (DIV_BITS),
      .DEFAULT_DIV (DEFAULT_DIV),
      .IDLE_CYC    (IDLE_CYC)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_rx     (rx),
      .i_start  (start),
      .o_div    (o_div),
      .o_busy   (o_busy),
      .o_locked (o_locked),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   always #5 clk = ~clk;

   // Compare one value and log it if it differs.
   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s/%s: got %0d expected %0d", curTest, name, actual, expected);
      end
   endtask

   function automatic exp_t mkExp(input logic is_err, input int div, input logic locked);
      exp_t e;
      e.is_err = is_err;
      e.div    = DIV_BITS'(div);
      e.locked = locked;
      return e;
   endfunction

   // Monitor: every done/err pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && (o_done || o_err)) begin
         checkOutput("done_err_exclusive", int'(o_done && o_err), 0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("event_is_err", int'(o_err), int'(mon_e.is_err));
            checkOutput("event_div", int'(o_div), int'(mon_e.div));
            checkOutput("event_locked", int'(o_locked), int'(mon_e.locked));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic holdRx(input logic v, input int n);
      rx = v;
      tick(n);
   endtask

   // 0x55 framed LSB first: start, 1,0,1,0,1,0,1,0, stop. Index 3 is bit2.
   task automatic sendFrame(input int bitClk, input int bit2Clk);
      logic [9:0] fr;
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
         holdRx(fr[i], (i == 3) ? bit2Clk : bitClk);
      end
   endtask

   // Wait (bounded) for every queued event to appear and busy to drop.
   task automatic waitSettled(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || o_busy) && k < budget) begin
         tick(1);
         k++;
      end
      checkOutput("settled", int'(exp_q.size() == 0 && !o_busy), 1);
      exp_q.delete();
   endtask

   task automatic applyStimulus(input string name, input int bitClk, input int bit2Clk, input exp_t e);
      curTest = name;
      pulseStart();
      holdRx(1'b1, 100);
      exp_q.push_back(e);
      sendFrame(bitClk, bit2Clk);
      waitSettled(500);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_div", int'(o_div), 26);
      checkOutput("rst_busy", int'(o_busy), 0);
      checkOutput("rst_locked", int'(o_locked), 0);
      checkOutput("rst_done", int'(o_done), 0);
      checkOutput("rst_err", int'(o_err), 0);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      start = 1'b0;
      tick(3);
      checkResetValues();
      rst = 1'b0;
      tick(5);

      applyStimulus("nominal_160", 160, 160, mkExp(1'b0, 9, 1'b1));
      applyStimulus("round_161", 161, 161, mkExp(1'b0, 9, 1'b1));
      applyStimulus("round_168", 168, 168, mkExp(1'b0, 10, 1'b1));
      applyStimulus("too_fast_16", 16, 16, mkExp(1'b1, 10, 1'b0));

      // The start edge arrives, then the line stays low until the counter saturates.
      curTest = "timeout";
      pulseStart();
      holdRx(1'b1, 100);
      exp_q.push_back(mkExp(1'b1, 10, 1'b0));
      rx = 1'b0;
      waitSettled(9000);
      checkOutput("div_kept", int'(o_div), 10);
      holdRx(1'b1, 100);

      // The line never stays high long enough, so the FSM remains armed.
      curTest = "idle_qual";
      pulseStart();
      for (int i = 0; i < 20; i++) begin
         holdRx((i % 2) == 1, 20);
      end
      holdRx(1'b1, 10);
      checkOutput("still_busy", int'(o_busy), 1);
      checkOutput("div_kept", int'(o_div), 10);
      #2 rst = 1'b1;
      #1 checkResetValues();
      tick(2);
      rst = 1'b0;
      tick(5);

      // Lock once, then reset partway through the next measurement.
      applyStimulus("relock_160", 160, 160, mkExp(1'b0, 9, 1'b1));
      curTest = "reset_mid";
      pulseStart();
      holdRx(1'b1, 100);
      holdRx(1'b0, 160);
      holdRx(1'b1, 160);
      holdRx(1'b0, 80);
      checkOutput("busy_measuring", int'(o_busy), 1);
      #2 rst = 1'b1;
      #1 checkResetValues();
      tick(2);
      rx  = 1'b1;
      rst = 1'b0;
      tick(300);
      checkOutput("no_event_after_reset", exp_q.size(), 0);

      // Stretch bit2 to 1.5 bit times, so T1 = 1.25*T0.
`ifdef AUTOBAUD_CHECK_EN
      applyStimulus("stretch_bit2", 160, 240, mkExp(1'b1, 26, 1'b0));
`else
      applyStimulus("stretch_bit2", 160, 240, mkExp(1'b0, 10, 1'b1));
`endif

      tick(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
